// File: rtl/resp_scoreboard.sv
// resp_scoreboard: FIFO of expected responses compared against observed ones.
// Define RESP_SCOREBOARD_CAPTURE_EN to add first-mismatch capture ports.
module resp_scoreboard #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_ready,
    input  logic              obs_valid,
    input  logic [DATA_W-1:0] obs_data,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              underflow,
    output logic              busy,
    output logic              done,
    output logic              pass
`ifdef RESP_SCOREBOARD_CAPTURE_EN
    ,
    output logic [DATA_W-1:0] first_exp,
    output logic [DATA_W-1:0] first_obs,
    output logic [CNT_W-1:0]  first_idx
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [AW:0]      PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              empty;
    logic              full;
    logic              active;
    logic              push;
    logic              pop;
    logic              uflow;
    logic              hit;
    logic              enter_run;
    logic [DATA_W-1:0] head;

    // Pointer-derived FIFO status plus the per-cycle push/pop/compare events
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        active    = (state == RUN) || (state == DRAIN);
        exp_ready = (state == RUN) && !full;
        push      = exp_valid && exp_ready;
        pop       = active && obs_valid && !empty;
        uflow     = active && obs_valid && empty;
        head      = mem[rd_ptr[AW-1:0]];
        hit       = (head == obs_data);
        enter_run = start && ((state == IDLE) || (state == DONE));
        busy      = active;
        done      = (state == DONE);
        pass      = done && (err_cnt == '0);
    end

    // Expected-value storage; contents are meaningless once pointers reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= exp_data;
        end
    end

    // Run-control FSM, FIFO pointers and saturating result counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            underflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (stop) state <= DRAIN;
                DRAIN:   if (empty) state <= DONE;
                DONE:    if (start) state <= RUN;
                default: state <= IDLE;
            endcase
            if (enter_run) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                match_cnt <= '0;
                err_cnt   <= '0;
                underflow <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                if (pop && hit && match_cnt != CNT_MAX)
                    match_cnt <= match_cnt + CNT_ONE;
                if (((pop && !hit) || uflow) && err_cnt != CNT_MAX)
                    err_cnt <= err_cnt + CNT_ONE;
                if (uflow) underflow <= 1'b1;
            end
        end
    end

`ifdef RESP_SCOREBOARD_CAPTURE_EN
    logic [CNT_W-1:0] cmp_idx;
    logic             captured;

    // Latch the first mismatching compare of a run; underflows never count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_idx   <= '0;
            captured  <= 1'b0;
            first_exp <= '0;
            first_obs <= '0;
            first_idx <= '0;
        end else if (enter_run) begin
            cmp_idx   <= '0;
            captured  <= 1'b0;
            first_exp <= '0;
            first_obs <= '0;
            first_idx <= '0;
        end else if (pop) begin
            if (cmp_idx != CNT_MAX) cmp_idx <= cmp_idx + CNT_ONE;
            if (!hit && !captured) begin
                captured  <= 1'b1;
                first_exp <= head;
                first_obs <= obs_data;
                first_idx <= cmp_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_resp_scoreboard.sv
// tb_resp_scoreboard: directed + random stimulus checked every cycle
// against a queue-based behavioural model of the scoreboard.
module tb_resp_scoreboard;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              exp_valid = 1'b0;
    logic [DATA_W-1:0] exp_data = '0;
    logic              exp_ready;
    logic              obs_valid = 1'b0;
    logic [DATA_W-1:0] obs_data = '0;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              underflow;
    logic              busy;
    logic              done;
    logic              pass;
`ifdef RESP_SCOREBOARD_CAPTURE_EN
    logic [DATA_W-1:0] first_exp;
    logic [DATA_W-1:0] first_obs;
    logic [CNT_W-1:0]  first_idx;
`endif

    resp_scoreboard #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .exp_valid(exp_valid),
        .exp_data (exp_data),
        .exp_ready(exp_ready),
        .obs_valid(obs_valid),
        .obs_data (obs_data),
        .match_cnt(match_cnt),
        .err_cnt  (err_cnt),
        .underflow(underflow),
        .busy     (busy),
        .done     (done),
        .pass     (pass)
`ifdef RESP_SCOREBOARD_CAPTURE_EN
        ,
        .first_exp(first_exp),
        .first_obs(first_obs),
        .first_idx(first_idx)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: queue of expected values and plain integer counts
    logic [DATA_W-1:0] mq[$];
    int m_st = M_IDLE;
    int m_match = 0;
    int m_err = 0;
    bit m_uf = 0;
    int m_cidx = 0;
    bit m_cap = 0;
    int m_fexp = 0;
    int m_fobs = 0;
    int m_fidx = 0;
    int occ;
    bit act;
    logic [DATA_W-1:0] h;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic clear_model();
        mq.delete();
        m_match = 0;
        m_err = 0;
        m_uf = 0;
        m_cidx = 0;
        m_cap = 0;
        m_fexp = 0;
        m_fobs = 0;
        m_fidx = 0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            clear_model();
            m_st = M_IDLE;
        end else begin
            occ = mq.size();
            act = (m_st == M_RUN) || (m_st == M_DRAIN);
            if (act && obs_valid) begin
                if (occ == 0) begin
                    m_uf = 1;
                    m_err = sat(m_err + 1);
                end else begin
                    h = mq.pop_front();
                    if (h == obs_data) begin
                        m_match = sat(m_match + 1);
                    end else begin
                        m_err = sat(m_err + 1);
                        if (!m_cap) begin
                            m_cap = 1;
                            m_fexp = int'(h);
                            m_fobs = int'(obs_data);
                            m_fidx = m_cidx;
                        end
                    end
                    m_cidx = sat(m_cidx + 1);
                end
            end
            if (m_st == M_RUN && occ < DEPTH && exp_valid)
                mq.push_back(exp_data);
            case (m_st)
                M_IDLE, M_DONE: if (start) begin
                    clear_model();
                    m_st = M_RUN;
                end
                M_RUN: if (stop) m_st = M_DRAIN;
                M_DRAIN: if (occ == 0) m_st = M_DONE;
                default: m_st = M_IDLE;
            endcase
        end
    end

    task automatic cmp(input string name, input int act_v, input int exp_v);
        vectors++;
        if (act_v != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act_v, exp_v, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        cmp("exp_ready", int'(exp_ready),
            int'(m_st == M_RUN && mq.size() < DEPTH));
        cmp("match_cnt", int'(match_cnt), m_match);
        cmp("err_cnt", int'(err_cnt), m_err);
        cmp("underflow", int'(underflow), int'(m_uf));
        cmp("busy", int'(busy),
            int'(m_st == M_RUN || m_st == M_DRAIN));
        cmp("done", int'(done), int'(m_st == M_DONE));
        cmp("pass", int'(pass), int'(m_st == M_DONE && m_err == 0));
`ifdef RESP_SCOREBOARD_CAPTURE_EN
        cmp("first_exp", int'(first_exp), m_fexp);
        cmp("first_obs", int'(first_obs), m_fobs);
        cmp("first_idx", int'(first_idx), m_fidx);
`endif
    end

    task automatic step(input bit s, input bit p,
                        input bit ev, input int ed,
                        input bit ov, input int od);
        start = s;
        stop = p;
        exp_valid = ev;
        exp_data = DATA_W'(ed);
        obs_valid = ov;
        obs_data = DATA_W'(od);
        @(posedge clk);
        #1;
        start = 0;
        stop = 0;
        exp_valid = 0;
        obs_valid = 0;
    endtask

    task automatic push(input int d);
        step(0, 0, 1, d, 0, 0);
    endtask

    task automatic obs(input int d);
        step(0, 0, 0, 0, 1, d);
    endtask

    task automatic finish_run();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int od;
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cmp("reset_busy", int'(busy), 0);
        cmp("reset_match", int'(match_cnt), 0);

        // Normal run: all four compares match
        step(1, 0, 0, 0, 0, 0);
        push(4'b0000);
        push(4'b1111);
        push(4'b1000);
        push(4'b1001);
        obs(4'b0000);
        obs(4'b1111);
        obs(4'b1000);
        obs(4'b1001);
        finish_run();
        cmp("normal_match", int'(match_cnt), 4);
        cmp("normal_err", int'(err_cnt), 0);
        cmp("normal_done", int'(done), 1);
        cmp("normal_pass", int'(pass), 1);

        // Single mismatch, visible one cycle after the observation
        step(1, 0, 0, 0, 0, 0);
        push(4'b1111);
        obs(4'b1110);
        cmp("mism_err", int'(err_cnt), 1);
        finish_run();
        cmp("mism_done", int'(done), 1);
        cmp("mism_pass", int'(pass), 0);
`ifdef RESP_SCOREBOARD_CAPTURE_EN
        cmp("cap_exp", int'(first_exp), 15);
        cmp("cap_obs", int'(first_obs), 14);
        cmp("cap_idx", int'(first_idx), 0);
`endif

        // Overfill then overdrain
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) push(i);
        cmp("full_ready", int'(exp_ready), 0);
        push(5);
        for (int i = 1; i <= 5; i++) obs(i);
        cmp("full_match", int'(match_cnt), 4);
        cmp("full_err", int'(err_cnt), 1);
        cmp("full_uflow", int'(underflow), 1);
        finish_run();

        // Simultaneous push+pop when full and when partially filled
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) push(i);
        step(0, 0, 1, 5, 1, 1);
        for (int i = 2; i <= 5; i++) obs(i);
        push(6);
        push(7);
        step(0, 0, 1, 8, 1, 6);
        obs(7);
        obs(8);
        cmp("simul_match", int'(match_cnt), 7);
        cmp("simul_err", int'(err_cnt), 1);
        finish_run();

        // Error counter saturation via repeated underflow
        step(1, 0, 0, 0, 0, 0);
        repeat (300) obs(0);
        cmp("sat_err", int'(err_cnt), CMAX);
        push(3);
        push(4);

        // Asynchronous reset mid-run
        rst_n = 0;
        #2;
        cmp("rst_match", int'(match_cnt), 0);
        cmp("rst_err", int'(err_cnt), 0);
        cmp("rst_uflow", int'(underflow), 0);
        cmp("rst_ready", int'(exp_ready), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_done", int'(done), 0);
        cmp("rst_pass", int'(pass), 0);
        @(posedge clk);
        #1 rst_n = 1;
        step(0, 1, 1, 5, 1, 5);
        cmp("idle_busy", int'(busy), 0);
        cmp("idle_ready", int'(exp_ready), 0);
        cmp("idle_err", int'(err_cnt), 0);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                @(posedge clk);
                #1 rst_n = 1;
            end
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                od = int'(mq[0]);
            else
                od = int'($urandom_range(0, 15));
            step($urandom_range(0, 29) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1,
                 od);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
